// File: rtl/instr_issue_ctrl_if.sv
// Handshake bundle between the instruction producer and the issue controller.
// The controller uses the slave modport; the producer/bench uses master.
interface instr_issue_ctrl_if;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic [31:0] issue_instr;
  logic        issue_valid;
  logic [15:0] stall_cnt;
  logic [1:0]  state;

  modport master (
    output flush, in_valid, in_instr,
    input  in_ready, issue_instr, issue_valid, stall_cnt, state
  );

  modport slave (
    input  flush, in_valid, in_instr,
    output in_ready, issue_instr, issue_valid, stall_cnt, state
  );
endinterface

// File: rtl/instr_issue_ctrl.sv
// Instruction queue plus register scoreboard that issues one instruction per
// clock into a 4-stage datapath, inserting bubbles on read-after-write hazards.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_EMPTY | queue empty (or flushed) at the last edge, bubble issued
// ST_ISSUE | head popped and issued (NOP issues as 32'h0 with valid=1)
// ST_STALL | head blocked by a busy source register, bubble issued
module instr_issue_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int HAZ_DEPTH  = 3
) (
  input logic            clk,
  input logic            rst,
  instr_issue_ctrl_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ISSUE = 2'b01,
    ST_STALL = 2'b10
  } state_t;

  state_t        state_q;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          sb_v  [HAZ_DEPTH];
  logic [4:0]    sb_rd [HAZ_DEPTH];
  logic [31:0]   issue_q;
  logic          valid_q;
  logic [15:0]   stall_q;

  logic [31:0] head;
  logic        empty;
  logic        head_nop;
  logic        head_rtype;
  logic        hazard;
  logic        push;
  logic        pop;

  assign head       = mem[rd_ptr];
  assign empty      = (count == '0);
  assign head_nop   = (head == 32'h0);
  assign head_rtype = (head[31:29] == 3'b010);

  assign bus.in_ready = (count != (AW+1)'(FIFO_DEPTH)) && !bus.flush;
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = !empty && !hazard && !bus.flush;

  assign bus.issue_instr = issue_q;
  assign bus.issue_valid = valid_q;
  assign bus.stall_cnt   = stall_q;
  assign bus.state       = state_q;

  // rt only counts as a source for R-type; NOPs never read anything
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZ_DEPTH; i++) begin
      if (sb_v[i] && ((sb_rd[i] == head[20:16]) ||
                      (head_rtype && (sb_rd[i] == head[15:11])))) begin
        hazard = 1'b1;
      end
    end
    if (empty || head_nop) begin
      hazard = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.in_instr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      for (int i = 0; i < HAZ_DEPTH; i++) begin
        sb_v[i]  <= 1'b0;
        sb_rd[i] <= 5'd0;
      end
      issue_q <= 32'h0;
      valid_q <= 1'b0;
      stall_q <= 16'h0;
      state_q <= ST_EMPTY;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      for (int i = 0; i < HAZ_DEPTH; i++) begin
        sb_v[i] <= 1'b0;
      end
      issue_q <= 32'h0;
      valid_q <= 1'b0;
      state_q <= ST_EMPTY;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      for (int i = HAZ_DEPTH - 1; i > 0; i--) begin
        sb_v[i]  <= sb_v[i-1];
        sb_rd[i] <= sb_rd[i-1];
      end
      sb_v[0]  <= pop && !head_nop;
      sb_rd[0] <= head[25:21];

      if (empty) begin
        issue_q <= 32'h0;
        valid_q <= 1'b0;
        state_q <= ST_EMPTY;
      end else if (hazard) begin
        issue_q <= 32'h0;
        valid_q <= 1'b0;
        if (stall_q != 16'hFFFF) stall_q <= stall_q + 1'b1;
        state_q <= ST_STALL;
      end else begin
        issue_q <= head;
        valid_q <= 1'b1;
        state_q <= ST_ISSUE;
      end
    end
  end
endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Directed bench for instr_issue_ctrl: a vector table for the main issue and
// hazard flow, then hand-built sequences for queue-full, flush and reset.
module tb_instr_issue_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  instr_issue_ctrl_if bus ();

  instr_issue_ctrl #(.FIFO_DEPTH(4), .HAZ_DEPTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] S_EMPTY = 2'b00;
  localparam logic [1:0] S_ISSUE = 2'b01;
  localparam logic [1:0] S_STALL = 2'b10;

  typedef struct {
    logic        fl;
    logic        vld;
    logic [31:0] ins;
    logic [31:0] e_instr;
    logic        e_valid;
    logic [1:0]  e_state;
    logic [15:0] e_stall;
  } vec_t;

  vec_t vecs [25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs, optionally check in_ready before the edge, then check the
  // registered outputs 1ns after the edge.
  task automatic step(input logic fl, input logic vld, input logic [31:0] ins,
                      input logic chk_rdy, input logic e_rdy,
                      input logic [31:0] e_instr, input logic e_valid,
                      input logic [1:0] e_state, input logic [15:0] e_stall,
                      input string tag);
    bus.flush    = fl;
    bus.in_valid = vld;
    bus.in_instr = ins;
    #1;
    if (chk_rdy) chk({tag, ".in_ready"}, {31'h0, bus.in_ready}, {31'h0, e_rdy});
    @(posedge clk);
    #1;
    chk({tag, ".issue_instr"}, bus.issue_instr, e_instr);
    chk({tag, ".issue_valid"}, {31'h0, bus.issue_valid}, {31'h0, e_valid});
    chk({tag, ".state"}, {30'h0, bus.state}, {30'h0, e_state});
    chk({tag, ".stall_cnt"}, {16'h0, bus.stall_cnt}, {16'h0, e_stall});
  endtask

  task automatic idle(input int n, input logic [15:0] e_stall, input string tag);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, S_EMPTY, e_stall, tag);
  endtask

  function automatic logic [31:0] mk_i(input logic [4:0] rd, input logic [4:0] rs);
    return {6'b011100, rd, rs, 16'h0001};
  endfunction

  localparam logic [31:0] P  = 32'h6821000A;  // r1 <- r1
  localparam logic [31:0] D  = 32'h70A10002;  // r5 <- r1
  localparam logic [31:0] X  = 32'h7C630003;  // r3 <- r3

  initial begin
    logic [31:0] i1, i2, i3, i4, i5;
    i1 = mk_i(5'd11, 5'd21);
    i2 = mk_i(5'd12, 5'd22);
    i3 = mk_i(5'd13, 5'd23);
    i4 = mk_i(5'd14, 5'd24);
    i5 = mk_i(5'd15, 5'd25);

    vecs[0]  = '{1'b0, 1'b1, 32'h6821000A, 32'h0,        1'b0, S_EMPTY, 16'd0};
    vecs[1]  = '{1'b0, 1'b1, 32'h70420002, 32'h6821000A, 1'b1, S_ISSUE, 16'd0};
    vecs[2]  = '{1'b0, 1'b1, 32'h48611000, 32'h70420002, 1'b1, S_ISSUE, 16'd0};
    vecs[3]  = '{1'b0, 1'b1, 32'h4C811000, 32'h0,        1'b0, S_STALL, 16'd1};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, S_STALL, 16'd2};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, S_STALL, 16'd3};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,        32'h48611000, 1'b1, S_ISSUE, 16'd3};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,        32'h4C811000, 1'b1, S_ISSUE, 16'd3};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, S_EMPTY, 16'd3};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, S_EMPTY, 16'd3};
    vecs[10] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, S_EMPTY, 16'd3};
    vecs[11] = '{1'b0, 1'b1, 32'h6821000A, 32'h0,        1'b0, S_EMPTY, 16'd3};
    vecs[12] = '{1'b0, 1'b1, 32'h0,        32'h6821000A, 1'b1, S_ISSUE, 16'd3};
    vecs[13] = '{1'b0, 1'b1, 32'h70A10002, 32'h0,        1'b1, S_ISSUE, 16'd3};
    vecs[14] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, S_STALL, 16'd4};
    vecs[15] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, S_STALL, 16'd5};
    vecs[16] = '{1'b0, 1'b0, 32'h0,        32'h70A10002, 1'b1, S_ISSUE, 16'd5};
    vecs[17] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, S_EMPTY, 16'd5};
    vecs[18] = '{1'b0, 1'b1, 32'h68000001, 32'h0,        1'b0, S_EMPTY, 16'd5};
    vecs[19] = '{1'b0, 1'b1, 32'h48E00000, 32'h68000001, 1'b1, S_ISSUE, 16'd5};
    vecs[20] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, S_STALL, 16'd6};
    vecs[21] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, S_STALL, 16'd7};
    vecs[22] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, S_STALL, 16'd8};
    vecs[23] = '{1'b0, 1'b0, 32'h0,        32'h48E00000, 1'b1, S_ISSUE, 16'd8};
    vecs[24] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, S_EMPTY, 16'd8};

    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_instr = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.issue_instr", bus.issue_instr, 32'h0);
    chk("rst.issue_valid", {31'h0, bus.issue_valid}, 32'h0);
    chk("rst.state", {30'h0, bus.state}, 32'h0);
    chk("rst.stall_cnt", {16'h0, bus.stall_cnt}, 32'h0);
    rst = 1'b1;
    #1;
    chk("rst.in_ready", {31'h0, bus.in_ready}, 32'h1);

    for (int v = 0; v < 25; v++)
      step(vecs[v].fl, vecs[v].vld, vecs[v].ins, 1'b1, 1'b1,
           vecs[v].e_instr, vecs[v].e_valid, vecs[v].e_state, vecs[v].e_stall,
           $sformatf("vec%0d", v));

    idle(3, 16'd8, "drain0");

    // Queue fills while D waits on P; the offer of i4 meets in_ready=0.
    step(1'b0, 1'b1, P,  1'b1, 1'b1, 32'h0, 1'b0, S_EMPTY, 16'd8,  "full0");
    step(1'b0, 1'b1, D,  1'b1, 1'b1, P,     1'b1, S_ISSUE, 16'd8,  "full1");
    step(1'b0, 1'b1, i1, 1'b1, 1'b1, 32'h0, 1'b0, S_STALL, 16'd9,  "full2");
    step(1'b0, 1'b1, i2, 1'b1, 1'b1, 32'h0, 1'b0, S_STALL, 16'd10, "full3");
    step(1'b0, 1'b1, i3, 1'b1, 1'b1, 32'h0, 1'b0, S_STALL, 16'd11, "full4");
    step(1'b0, 1'b1, i4, 1'b1, 1'b0, D,     1'b1, S_ISSUE, 16'd11, "full5");
    step(1'b0, 1'b1, i5, 1'b1, 1'b1, i1,    1'b1, S_ISSUE, 16'd11, "full6");
    step(1'b0, 1'b0, 0,  1'b1, 1'b1, i2,    1'b1, S_ISSUE, 16'd11, "full7");
    step(1'b0, 1'b0, 0,  1'b1, 1'b1, i3,    1'b1, S_ISSUE, 16'd11, "full8");
    step(1'b0, 1'b0, 0,  1'b1, 1'b1, i5,    1'b1, S_ISSUE, 16'd11, "full9");
    idle(3, 16'd11, "drain1");

    // Flush while stalled with D, i1, i2 queued; coincident offer is refused.
    step(1'b0, 1'b1, P,  1'b1, 1'b1, 32'h0, 1'b0, S_EMPTY, 16'd11, "fl0");
    step(1'b0, 1'b1, D,  1'b1, 1'b1, P,     1'b1, S_ISSUE, 16'd11, "fl1");
    step(1'b0, 1'b1, i1, 1'b1, 1'b1, 32'h0, 1'b0, S_STALL, 16'd12, "fl2");
    step(1'b0, 1'b1, i2, 1'b1, 1'b1, 32'h0, 1'b0, S_STALL, 16'd13, "fl3");
    step(1'b1, 1'b1, i3, 1'b1, 1'b0, 32'h0, 1'b0, S_EMPTY, 16'd13, "fl4");
    idle(6, 16'd13, "flpost");

    // Asynchronous reset mid-stall, between edges.
    step(1'b0, 1'b1, P, 1'b1, 1'b1, 32'h0, 1'b0, S_EMPTY, 16'd13, "rs0");
    step(1'b0, 1'b1, D, 1'b1, 1'b1, P,     1'b1, S_ISSUE, 16'd13, "rs1");
    step(1'b0, 1'b0, 0, 1'b1, 1'b1, 32'h0, 1'b0, S_STALL, 16'd14, "rs2");
    #2;
    rst = 1'b0;
    #1;
    chk("rs.issue_instr", bus.issue_instr, 32'h0);
    chk("rs.issue_valid", {31'h0, bus.issue_valid}, 32'h0);
    chk("rs.state", {30'h0, bus.state}, 32'h0);
    chk("rs.stall_cnt", {16'h0, bus.stall_cnt}, 32'h0);
    #1;
    rst = 1'b1;
    step(1'b0, 1'b1, X, 1'b1, 1'b1, 32'h0, 1'b0, S_EMPTY, 16'd0, "rs3");
    step(1'b0, 1'b0, 0, 1'b1, 1'b1, X,     1'b1, S_ISSUE, 16'd0, "rs4");
    idle(4, 16'd0, "rspost");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
